// File: rtl/gpi_debounce.sv
// rtl/gpi_debounce.sv - per-channel synchroniser, counter debounce, polarity and rise/fall events
// Optional sticky event flags: GPI_DEBOUNCE_EVENT_LATCH_EN
module gpi_debounce #(
  parameter int              NumIn          = 7,
  parameter int              SyncStages     = 2,
  parameter int              DebounceCycles = 500000,
  parameter logic [NumIn-1:0] InvertMask    = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [NumIn-1:0] raw_i,
  output logic [NumIn-1:0] level_o,
  output logic [NumIn-1:0] rise_o,
  output logic [NumIn-1:0] fall_o,
  output logic [NumIn-1:0] evt_pending_o,
  input  logic [NumIn-1:0] evt_clr_i
);

  localparam int              CntW    = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [SyncStages-1:0][NumIn-1:0] sync_q;
  logic [NumIn-1:0]                 sync_s;
  logic [NumIn-1:0]                 stable_q;
  logic [NumIn-1:0][CntW-1:0]       cnt_q;
  logic [NumIn-1:0]                 prev_q;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], raw_i};
    end
  end

  assign sync_s = sync_q[SyncStages-1];

  // Any sample agreeing with the stable value restarts the count, so only an
  // unbroken run of DebounceCycles differing samples is accepted.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < NumIn; i++) begin
        if (sync_s[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntLast) begin
          stable_q[i] <= sync_s[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CntOne;
        end
      end
    end
  end

  assign level_o = stable_q ^ InvertMask;

  // prev_q resets to the reset-time level so reset release never looks like an edge.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      prev_q <= InvertMask;
    end else begin
      prev_q <= level_o;
    end
  end

  assign rise_o = level_o & ~prev_q;
  assign fall_o = ~level_o & prev_q;

`ifdef GPI_DEBOUNCE_EVENT_LATCH_EN
  logic [NumIn-1:0] evt_q;

  // A new event outranks a clear arriving in the same cycle.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      evt_q <= '0;
    end else begin
      evt_q <= (evt_q & ~evt_clr_i) | rise_o | fall_o;
    end
  end

  assign evt_pending_o = evt_q;
`else
  logic unused_evt_clr;

  assign unused_evt_clr = ^evt_clr_i;
  assign evt_pending_o  = '0;
`endif

endmodule

// File: tb/tb_gpi_debounce.sv
// tb/tb_gpi_debounce.sv - directed and random checks of gpi_debounce against a sample-window model
module tb_gpi_debounce;

  localparam int         N    = 7;
  localparam int         SS   = 2;
  localparam int         DC   = 4;
  localparam logic [6:0] MASK = 7'b0000111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] raw = '0;
  logic [6:0] clr = '0;
  logic [6:0] level, rise, fall, evt;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] hist[$];
  logic [6:0] d_m, prev_m, evt_m;
  logic [6:0] acc;

  gpi_debounce #(
    .NumIn(N), .SyncStages(SS), .DebounceCycles(DC), .InvertMask(MASK)
  ) dut (
    .clk_sys_i(clk),
    .rst_sys_ni(rst_n),
    .raw_i(raw),
    .level_o(level),
    .rise_o(rise),
    .fall_o(fall),
    .evt_pending_o(evt),
    .evt_clr_i(clr)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    hist.delete();
    d_m    = '0;
    prev_m = MASK;
    evt_m  = '0;
  endtask

  // A channel's accepted value flips once the last DC post-sync samples all
  // disagree with it; the post-sync sample at edge k is raw from edge k-SS.
  task automatic model_edge();
    logic [6:0] lv_old, all_diff, s;
    int t;
    if (!rst_n) begin
      model_reset();
      return;
    end
    lv_old = d_m ^ MASK;
`ifdef GPI_DEBOUNCE_EVENT_LATCH_EN
    evt_m = (evt_m & ~clr) | (lv_old & ~prev_m) | (~lv_old & prev_m);
`endif
    prev_m = lv_old;
    hist.push_back(raw);
    t = hist.size();
    if (t >= DC) begin
      all_diff = '1;
      for (int k = t - DC + 1; k <= t; k++) begin
        s = (k - SS >= 1) ? hist[k - SS - 1] : 7'h00;
        all_diff &= s ^ d_m;
      end
      d_m ^= all_diff;
    end
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [6:0] lv;
    lv = d_m ^ MASK;
    chk("level", level, lv);
    chk("rise", rise, lv & ~prev_m);
    chk("fall", fall, ~lv & prev_m);
    chk("evt", evt, evt_m);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    chk("rst_level", level, 7'h07);
    rst_n = 1'b1;
    repeat (4) tick();

    // steady press on channel 6
    raw[6] = 1'b1;
    repeat (5) tick();
    chk("press_early", {6'b0, level[6]}, 7'd0);
    tick();
    chk("press_level", {6'b0, level[6]}, 7'd1);
    chk("press_rise", {6'b0, rise[6]}, 7'd1);
    tick();
    chk("press_rise_1cyc", {6'b0, rise[6]}, 7'd0);
`ifdef GPI_DEBOUNCE_EVENT_LATCH_EN
    chk("evt_set", {6'b0, evt[6]}, 7'd1);
    repeat (3) tick();
    chk("evt_held", {6'b0, evt[6]}, 7'd1);
    clr[6] = 1'b1;
    tick();
    clr[6] = 1'b0;
    chk("evt_clr", {6'b0, evt[6]}, 7'd0);
`else
    repeat (3) tick();
    chk("evt_off", evt, 7'd0);
`endif

    // 3-cycle glitch on channel 5
    raw[5] = 1'b1;
    acc = '0;
    repeat (3) begin tick(); acc |= (level | rise | fall) & 7'h20; end
    raw[5] = 1'b0;
    repeat (10) begin tick(); acc |= (level | rise | fall) & 7'h20; end
    chk("glitch", acc, 7'd0);

    // inverted channel 0
    raw[0] = 1'b1;
    repeat (5) tick();
    chk("inv_early", {6'b0, level[0]}, 7'd1);
    tick();
    chk("inv_level", {6'b0, level[0]}, 7'd0);
    chk("inv_fall", {6'b0, fall[0]}, 7'd1);
    tick();
    chk("inv_fall_1cyc", {6'b0, fall[0]}, 7'd0);

    // channels 4 and 3 together
    raw[4] = 1'b1;
    raw[3] = 1'b1;
    repeat (5) tick();
    chk("simul_early", {5'b0, level[4:3]}, 7'd0);
    tick();
    chk("simul_level", {5'b0, level[4:3]}, 7'd3);
    chk("simul_rise", {5'b0, rise[4:3]}, 7'd3);

    // release channel 6, clear in the same cycle as its fall
    raw[6] = 1'b0;
    for (int i = 0; i < 20 && !fall[6]; i++) tick();
    chk("fall6_seen", {6'b0, fall[6]}, 7'd1);
    clr[6] = 1'b1;
    tick();
    clr[6] = 1'b0;
`ifdef GPI_DEBOUNCE_EVENT_LATCH_EN
    chk("evt_set_wins", {6'b0, evt[6]}, 7'd1);
`else
    chk("evt_set_wins", {6'b0, evt[6]}, 7'd0);
`endif
    tick();

    // asynchronous reset mid-count
    raw = 7'h7F;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_level", level, 7'h07);
    chk("midrst_rise", rise, 7'h00);
    chk("midrst_fall", fall, 7'h00);
    chk("midrst_evt", evt, 7'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();

    // random toggling with random clears
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) raw ^= 7'($urandom) & 7'($urandom);
      clr = 7'($urandom) & 7'($urandom) & 7'($urandom);
      tick();
    end
    clr = '0;
    repeat (12) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
